// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters through an IDLE/ISSUE/RESP sequencer.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module alu_share_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_ctrl,
  input  logic [4:0]  req0_shamt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_ctrl,
  input  logic [4:0]  req1_shamt,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_ctrl,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on request data, and a response holds its data until rsp ready is seen.

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        grant_q;
  logic [31:0] op_a_q, op_b_q;
  logic [5:0]  op_ctrl_q;
  logic [4:0]  op_shamt_q;
  logic        op_illegal_q;
  logic [31:0] res_result_q;
  logic        res_zero_q, res_err_q;
  logic        win0, win1, acc0, acc1, rsp_hs;
  logic [31:0] sel_a, sel_b;
  logic [5:0]  sel_ctrl;
  logic [4:0]  sel_shamt;

  function automatic logic ctrl_legal(input logic [5:0] c);
    case (c)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b000000, 6'b000010, 6'b000011,
      6'b000100, 6'b000110, 6'b000111: ctrl_legal = 1'b1;
      default:                         ctrl_legal = 1'b0;
    endcase
  endfunction

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // last_grant_q = 1 means port 1 was granted last, so port 0 wins the next tie.
  logic last_grant_q;

  always_comb begin
    win0 = req0_valid & (~req1_valid | last_grant_q);
    win1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (acc0 | acc1) begin
      last_grant_q <= acc1;
    end
  end
`else
  always_comb begin
    win0 = req0_valid;
    win1 = req1_valid & ~req0_valid;
  end
`endif

  assign req0_ready = (state == IDLE) & win0;
  assign req1_ready = (state == IDLE) & win1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  assign sel_a     = acc1 ? req1_a     : req0_a;
  assign sel_b     = acc1 ? req1_b     : req0_b;
  assign sel_ctrl  = acc1 ? req1_ctrl  : req0_ctrl;
  assign sel_shamt = acc1 ? req1_shamt : req0_shamt;

  assign rsp_hs = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc0 | acc1) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= '0;
      op_shamt_q   <= '0;
      op_illegal_q <= 1'b0;
      res_result_q <= '0;
      res_zero_q   <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc0 | acc1) begin
        grant_q      <= acc1;
        op_a_q       <= sel_a;
        op_b_q       <= sel_b;
        op_ctrl_q    <= sel_ctrl;
        op_shamt_q   <= sel_shamt;
        op_illegal_q <= ~ctrl_legal(sel_ctrl);
      end
      // Illegal codes never forward the ALU's undefined output.
      if (state == ISSUE) begin
        res_result_q <= op_illegal_q ? 32'd0 : alu_result;
        res_zero_q   <= op_illegal_q ? 1'b1  : alu_zero;
        res_err_q    <= op_illegal_q;
      end
    end
  end

  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_ctrl  = op_ctrl_q;
  assign alu_shamt = op_shamt_q;

  assign rsp0_valid  = (state == RESP) & ~grant_q;
  assign rsp1_valid  = (state == RESP) &  grant_q;
  assign rsp0_result = rsp0_valid ? res_result_q : 32'd0;
  assign rsp0_zero   = rsp0_valid & res_zero_q;
  assign rsp0_err    = rsp0_valid & res_err_q;
  assign rsp1_result = rsp1_valid ? res_result_q : 32'd0;
  assign rsp1_zero   = rsp1_valid & res_zero_q;
  assign rsp1_err    = rsp1_valid & res_err_q;

  assign dbg_state = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural ALU, vector table, scenario sequences and randomized contention.
module tb_alu_share_arbiter;

  localparam int W = 35;  // {port, err, zero, result}

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_ctrl, req1_ctrl;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0]  alu_ctrl;
  logic [4:0]  alu_shamt;
  logic        alu_zero;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int rr_next = 0;
  logic [W-1:0] exp_q[$];
  int grant_log[$];
  int accept_cyc[$];

  typedef struct {
    logic [31:0] a, b;
    logic [5:0]  c;
    logic [4:0]  s;
  } op_t;
  op_t q0[$];
  op_t q1[$];

  typedef struct {
    int          port;
    logic [31:0] a, b;
    logic [5:0]  c;
    logic [4:0]  s;
    logic [31:0] er;
    logic        ez, ee;
  } vec_t;

  logic [5:0] legal_codes [15] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                   6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000000,
                                   6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111};

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .req0_shamt(req0_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .req1_shamt(req1_shamt),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- behavioural ALU and reference ----------------
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] c, input logic [4:0] s);
    case (c)
      6'b100000, 6'b100001: return a + b;
      6'b100010, 6'b100011: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b000000: return b << s;
      6'b000010: return b >> s;
      6'b000011: return $unsigned($signed(b) >>> s);
      6'b000100: return b << a[4:0];
      6'b000110: return b >> a[4:0];
      6'b000111: return $unsigned($signed(b) >>> a[4:0]);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl, alu_shamt);
  assign alu_zero   = (alu_result == 32'd0);

  function automatic bit is_legal(input logic [5:0] c);
    foreach (legal_codes[i]) if (legal_codes[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [33:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] c, input logic [4:0] s);
    logic [31:0] r;
    if (!is_legal(c)) return {1'b1, 1'b1, 32'd0};
    r = alu_fn(a, b, c, s);
    return {1'b0, (r == 32'd0), r};
  endfunction

  function automatic int tie_pick();
`ifdef ALU_ARB_ROUND_ROBIN_EN
    return rr_next;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver helpers ----------------
  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] c, input logic [4:0] s);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c; req0_shamt = s;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c; req1_shamt = s;
    end
  endtask

  task automatic set_rsp_ready(input int p, input logic v);
    if (p == 0) rsp0_ready = v;
    else        rsp1_ready = v;
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rvalid(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [33:0] rpack(input int p);
    return (p == 0) ? {rsp0_err, rsp0_zero, rsp0_result} : {rsp1_err, rsp1_zero, rsp1_result};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ":rsp_valid"}, {rsp1_valid, rsp0_valid}, 0);
    check({nm, ":rsp0"}, rpack(0), 0);
    check({nm, ":rsp1"}, rpack(1), 0);
    check({nm, ":alu_a"}, alu_a, 0);
    check({nm, ":alu_b"}, alu_b, 0);
    check({nm, ":alu_ctrl"}, alu_ctrl, 0);
    check({nm, ":alu_shamt"}, alu_shamt, 0);
    check({nm, ":req_ready"}, {req1_ready, req0_ready}, 0);
    check({nm, ":state"}, dbg_state, 0);
  endtask

  // One isolated operation on port p with cycle-exact timing checks.
  task automatic do_op(input string nm, input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] c, input logic [4:0] s, input logic [33:0] exp);
    int o = 1 - p;
    @(negedge clk);
    set_req(p, 1'b1, a, b, c, s);
    #1;
    check({nm, ":ready"}, rdy(p), 1);
    check({nm, ":other_ready"}, rdy(o), 0);
    if (rdy(p)) rr_next = o;
    @(negedge clk);
    set_req(p, 1'b0, '0, '0, '0, '0);
    #1;
    check({nm, ":issue_state"}, dbg_state, 1);
    check({nm, ":issue_no_rsp"}, {rsp1_valid, rsp0_valid}, 0);
    check({nm, ":alu_a"}, alu_a, a);
    check({nm, ":alu_b"}, alu_b, b);
    check({nm, ":alu_ctrl"}, alu_ctrl, c);
    check({nm, ":alu_shamt"}, alu_shamt, s);
    @(negedge clk);
    #1;
    check({nm, ":rsp_valid"}, rvalid(p), 1);
    check({nm, ":other_rsp_valid"}, rvalid(o), 0);
    check({nm, ":rsp_data"}, rpack(p), exp);
    check({nm, ":other_rsp_data"}, rpack(o), 0);
    set_rsp_ready(p, 1'b1);
    @(negedge clk);
    set_rsp_ready(p, 1'b0);
    #1;
    check({nm, ":back_idle"}, dbg_state, 0);
    check({nm, ":rsp_dropped"}, rvalid(p), 0);
  endtask

  // Drives both queues concurrently and checks grants, timing and responses against the spec rules.
  task automatic run_contention(input string nm, input bit rnd);
    int cyc = 0;
    int phase = 0;
    int cur = 0;
    int w;
    bit v0, v1;
    op_t op;
    grant_log.delete();
    accept_cyc.delete();
    exp_q.delete();
    while ((q0.size() + q1.size() > 0 || phase != 0) && cyc < 600) begin
      @(negedge clk);
      v0 = (q0.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      v1 = (q1.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      if (q0.size() > 0) set_req(0, v0, q0[0].a, q0[0].b, q0[0].c, q0[0].s);
      else               set_req(0, 1'b0, '0, '0, '0, '0);
      if (q1.size() > 0) set_req(1, v1, q1[0].a, q1[0].b, q1[0].c, q1[0].s);
      else               set_req(1, 1'b0, '0, '0, '0, '0);
      rsp0_ready = !rnd || ($urandom_range(0, 1) == 1);
      rsp1_ready = !rnd || ($urandom_range(0, 1) == 1);
      #1;
      if (phase == 0) begin
        check({nm, ":idle_no_rsp"}, {rsp1_valid, rsp0_valid}, 0);
        if (v0 || v1) begin
          w = (v0 && v1) ? tie_pick() : (v0 ? 0 : 1);
          check({nm, ":grant"}, {req1_ready, req0_ready}, (w == 1) ? 2'b10 : 2'b01);
          op = (w == 1) ? q1.pop_front() : q0.pop_front();
          exp_q.push_back({w[0], exp_rsp(op.a, op.b, op.c, op.s)});
          grant_log.push_back(w);
          accept_cyc.push_back(cyc);
          rr_next = 1 - w;
          cur = w;
          phase = 1;
        end else begin
          check({nm, ":no_req_ready"}, {req1_ready, req0_ready}, 0);
        end
      end else if (phase == 1) begin
        check({nm, ":issue_ready"}, {req1_ready, req0_ready}, 0);
        check({nm, ":issue_no_rsp"}, {rsp1_valid, rsp0_valid}, 0);
        phase = 2;
      end else begin
        check({nm, ":resp_ready"}, {req1_ready, req0_ready}, 0);
        check({nm, ":resp_valid"}, {rsp1_valid, rsp0_valid}, (cur == 1) ? 2'b10 : 2'b01);
        check({nm, ":resp_data"}, {cur[0], rpack(cur)}, exp_q[0]);
        if ((cur == 0) ? rsp0_ready : rsp1_ready) begin
          void'(exp_q.pop_front());
          phase = 0;
        end
      end
      cyc++;
    end
    check({nm, ":completed_in_budget"}, (q0.size() + q1.size() > 0 || phase != 0), 0);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl[12];
    op_t  op;
    int   p, exp_g;
    logic [5:0] c;

    tbl[0]  = '{0, 32'd5,          32'd7,          6'b100000, 5'd0,  32'd12,         1'b0, 1'b0};
    tbl[1]  = '{1, 32'd0,          32'h8000_0000,  6'b000011, 5'd4,  32'hF800_0000,  1'b0, 1'b0};
    tbl[2]  = '{1, 32'd9,          32'd9,          6'b100010, 5'd0,  32'd0,          1'b1, 1'b0};
    tbl[3]  = '{0, 32'd5,          32'd7,          6'b111111, 5'd0,  32'd0,          1'b1, 1'b1};
    tbl[4]  = '{0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  6'b100100, 5'd0,  32'h00F0_00F0,  1'b0, 1'b0};
    tbl[5]  = '{1, 32'hFFFF_FFFF,  32'd1,          6'b101010, 5'd0,  32'd1,          1'b0, 1'b0};
    tbl[6]  = '{0, 32'd0,          32'd0,          6'b100111, 5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0};
    tbl[7]  = '{1, 32'd3,          32'd1,          6'b000100, 5'd0,  32'd8,          1'b0, 1'b0};
    tbl[8]  = '{1, 32'd1,          32'd2,          6'b000001, 5'd0,  32'd0,          1'b1, 1'b1};
    tbl[9]  = '{0, 32'd1,          32'd2,          6'b101011, 5'd0,  32'd0,          1'b1, 1'b1};
    tbl[10] = '{0, 32'd0,          32'h8000_0000,  6'b000010, 5'd31, 32'd1,          1'b0, 1'b0};
    tbl[11] = '{1, 32'd7,          32'd7,          6'b100110, 5'd0,  32'd0,          1'b1, 1'b0};

    rst_n = 1'b0;
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    rr_next = 0;

    // Both ports continuously valid, responses consumed immediately.
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{32'd1, 32'd1, 6'b100000, 5'd0});
      q1.push_back('{32'd3, 32'd4, 6'b100101, 5'd0});
    end
    run_contention("contend", 1'b0);
    check("contend:grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_g = i % 2;
`else
      exp_g = (i < 4) ? 0 : 1;
`endif
      check($sformatf("contend:grant_order[%0d]", i), grant_log[i], exp_g);
      if (i > 0) check($sformatf("contend:gap[%0d]", i), accept_cyc[i] - accept_cyc[i-1], 3);
    end

    foreach (tbl[i])
      do_op($sformatf("vec%0d", i), tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s,
            {tbl[i].ee, tbl[i].ez, tbl[i].er});

    for (int i = 0; i < 30; i++) begin
      p = $urandom_range(0, 1);
      c = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : legal_codes[$urandom_range(0, 14)];
      op = '{$urandom, $urandom, c, 5'($urandom_range(0, 31))};
      do_op($sformatf("rand%0d", i), p, op.a, op.b, op.c, op.s, exp_rsp(op.a, op.b, op.c, op.s));
    end

    for (int i = 0; i < 10; i++) begin
      q0.push_back('{$urandom, $urandom, legal_codes[$urandom_range(0, 14)], 5'($urandom_range(0, 31))});
      q1.push_back('{$urandom, $urandom, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31))});
    end
    run_contention("rcontend", 1'b1);

    // Backpressure: response held for 5 cycles while both ports request.
    @(negedge clk);
    set_req(0, 1'b1, 32'd20, 32'd22, 6'b100000, 5'd0);
    #1;
    check("bp:accept", req0_ready, 1);
    rr_next = 1;
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    set_req(0, 1'b1, 32'd1, 32'd1, 6'b100000, 5'd0);
    set_req(1, 1'b1, 32'd3, 32'd4, 6'b100101, 5'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp:valid[%0d]", i), rsp0_valid, 1);
      check($sformatf("bp:result[%0d]", i), rsp0_result, 32'd42);
      check($sformatf("bp:req_ready[%0d]", i), {req1_ready, req0_ready}, 0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("bp:idle_after_release", dbg_state, 0);
    check("bp:rsp_dropped", rsp0_valid, 0);
    check("bp:tie_grant", {req1_ready, req0_ready}, (tie_pick() == 1) ? 2'b10 : 2'b01);
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);

    // Reset pulse during ISSUE drops the operation.
    @(negedge clk);
    set_req(1, 1'b1, 32'd100, 32'd1, 6'b100010, 5'd0);
    #1;
    check("rst:accept", req1_ready, 1);
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0, '0);
    #1;
    check("rst:in_issue", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    rr_next = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst:no_rsp[%0d]", i), {rsp1_valid, rsp0_valid, dbg_state}, 0);
    end
    do_op("post_rst", 0, 32'd5, 32'd7, 6'b100000, 5'd0, {1'b0, 1'b0, 32'd12});

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
